// File: rtl/env_vca.sv
// Attack/sustain/release envelope generator and VCA for the eurorack-pmod chain.
// Define ENV_VCA_EXP_RELEASE_EN for exponential release; linear release otherwise.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | envelope parked at 0, waiting for a gate rising edge
// S_ATTACK  | env rises by ainc per sample, saturating at full scale
// S_SUSTAIN | env held at full scale while the gate stays high
// S_RELEASE | env falls toward 0; reaching 0 fires the end-of-cycle pulse
module env_vca #(
    parameter int W           = 16,
    parameter int GATE_ON     = 4000,
    parameter int GATE_OFF    = 2000,
    parameter int PULSE_LEVEL = 20000
) (
    input  logic                sample_clk,
    input  logic                rst,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    input  logic [7:0]          jack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [23:0]         ENV_MAX = 24'hFFFFFF;
    localparam logic signed [W-1:0] TH_ON   = W'(GATE_ON);
    localparam logic signed [W-1:0] TH_OFF  = W'(GATE_OFF);
    localparam logic signed [W-1:0] PULSE   = W'(PULSE_LEVEL);
    localparam logic signed [W-1:0] CV_MAX  = W'(32767);

    state_t r_state;
    state_t w_state_nxt;
    logic [23:0] r_env;
    logic [23:0] w_env_nxt;
    logic        r_gate;
    logic        w_gate_nxt;
    logic        w_eoc;

    logic [14:0]          w_ca;
    logic [14:0]          w_cr;
    logic [13:0]          w_ainc;
    logic [24:0]          w_sum;
    logic                 w_att_sat;
    logic [23:0]          w_env_att;
    logic [23:0]          w_dec;
    logic                 w_rel_zero;
    logic [23:0]          w_env_rel;
    logic [15:0]          w_lvl;
    logic signed [W+16:0] w_prod;
    logic                 w_unused_bits;

    function automatic logic [14:0] clamp_cv(input logic signed [W-1:0] v);
        logic [14:0] c;
        if (v[W-1])
            c = '0;
        else if (v > CV_MAX)
            c = 15'h7FFF;
        else
            c = v[14:0];
        return c;
    endfunction

    always_comb begin
        w_gate_nxt = r_gate;
        if (sample_in1 >= TH_ON)
            w_gate_nxt = 1'b1;
        else if (sample_in1 < TH_OFF)
            w_gate_nxt = 1'b0;
    end

    assign w_ca = clamp_cv(sample_in2);
    assign w_cr = clamp_cv(sample_in3);

    // (32767 - c) is just ~c for a 15-bit c
    assign w_ainc    = {1'b0, ~w_ca[14:2]} + 14'd1;
    assign w_sum     = {1'b0, r_env} + {11'd0, w_ainc};
    assign w_att_sat = (w_sum >= {1'b0, ENV_MAX});
    assign w_env_att = w_att_sat ? ENV_MAX : w_sum[23:0];

`ifdef ENV_VCA_EXP_RELEASE_EN
    logic [3:0]  w_shamt;
    logic [23:0] w_shr;
    assign w_shamt = 4'd4 + {1'b0, w_cr[14:12]};
    assign w_shr   = r_env >> w_shamt;
    // Tail of the exponential would stall forever without the minimum step of 1
    assign w_dec   = (w_shr == 24'd0) ? 24'd1 : w_shr;
    assign w_unused_bits = ^{jack, w_prod[15:0], w_prod[W+16], w_ca[1:0], w_cr[11:0]};
`else
    logic [13:0] w_rdec;
    assign w_rdec = {1'b0, ~w_cr[14:2]} + 14'd1;
    assign w_dec  = {10'd0, w_rdec};
    assign w_unused_bits = ^{jack, w_prod[15:0], w_prod[W+16], w_ca[1:0], w_cr[1:0]};
`endif

    assign w_rel_zero = (r_env <= w_dec);
    assign w_env_rel  = w_rel_zero ? 24'd0 : (r_env - w_dec);

    assign w_lvl  = r_env[23:8];
    assign w_prod = sample_in0 * $signed({1'b0, w_lvl});

    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_eoc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_env_nxt = 24'd0;
                if (w_gate_nxt && !r_gate)
                    w_state_nxt = S_ATTACK;
            end
            S_ATTACK: begin
                w_env_nxt = w_env_att;
                if (!w_gate_nxt)
                    w_state_nxt = S_RELEASE;
                else if (w_att_sat)
                    w_state_nxt = S_SUSTAIN;
            end
            S_SUSTAIN: begin
                w_env_nxt = ENV_MAX;
                if (!w_gate_nxt)
                    w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                w_env_nxt = w_env_rel;
                // A retrigger landing on the zero crossing suppresses the EOC
                if (w_gate_nxt)
                    w_state_nxt = S_ATTACK;
                else if (w_rel_zero) begin
                    w_state_nxt = S_IDLE;
                    w_eoc       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_env_nxt   = 24'd0;
            end
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_env       <= 24'd0;
            r_gate      <= 1'b0;
            sample_out0 <= '0;
            sample_out1 <= '0;
            sample_out2 <= '0;
            sample_out3 <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_env       <= w_env_nxt;
            r_gate      <= w_gate_nxt;
            sample_out0 <= w_prod[W+15:16];
            sample_out1 <= W'({1'b0, w_lvl[15:1]});
            sample_out2 <= w_gate_nxt ? PULSE : '0;
            sample_out3 <= w_eoc ? PULSE : '0;
        end
    end

endmodule

// File: tb/tb_env_vca.sv
// Scoreboard bench for env_vca: a behavioural model queues the expected outputs
// for each edge, and the queue is drained against the DUT one edge later.
module tb_env_vca;

    logic               sample_clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic signed [15:0] out0, out1, out2, out3;
    logic [7:0]         jack = 8'h00;

    env_vca dut (
        .sample_clk (sample_clk),
        .rst        (rst),
        .sample_in0 (in0),
        .sample_in1 (in1),
        .sample_in2 (in2),
        .sample_in3 (in3),
        .sample_out0(out0),
        .sample_out1(out1),
        .sample_out2(out2),
        .sample_out3(out3),
        .jack       (jack)
    );

    always #5 sample_clk = ~sample_clk;

    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // model state: 0 idle, 1 attack, 2 sustain, 3 release
    int m_env = 0;
    int m_st  = 0;
    bit m_gate = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clampv(input logic signed [15:0] v);
        return (v < 0) ? 0 : int'(v);
    endfunction

    function automatic int model_ainc();
        return ((32767 - clampv(in2)) >> 2) + 1;
    endfunction

    function automatic int model_dec();
        int d;
`ifdef ENV_VCA_EXP_RELEASE_EN
        d = m_env >> (4 + (clampv(in3) >> 12));
        if (d < 1) d = 1;
`else
        d = ((32767 - clampv(in3)) >> 2) + 1;
`endif
        return d;
    endfunction

    task automatic model_edge();
        int lvl, o0, o1, o2, o3;
        bit ng;
        longint p;
        lvl = m_env >> 8;
        p   = longint'(in0) * longint'(lvl);
        o0  = int'(p >>> 16);
        o1  = lvl >> 1;
        o3  = 0;
        if (rst) begin
            m_env = 0; m_st = 0; m_gate = 1'b0;
            exp_q.push_back(64'd0);
        end else begin
            ng = m_gate;
            if (in1 >= 4000) ng = 1'b1;
            else if (in1 < 2000) ng = 1'b0;
            case (m_st)
                0: begin
                    m_env = 0;
                    if (ng && !m_gate) m_st = 1;
                end
                1: begin
                    m_env = m_env + model_ainc();
                    if (m_env > 24'hFFFFFF) m_env = 24'hFFFFFF;
                    if (!ng) m_st = 3;
                    else if (m_env == 24'hFFFFFF) m_st = 2;
                end
                2: begin
                    m_env = 24'hFFFFFF;
                    if (!ng) m_st = 3;
                end
                default: begin
                    m_env = m_env - model_dec();
                    if (m_env < 0) m_env = 0;
                    if (ng) m_st = 1;
                    else if (m_env == 0) begin
                        m_st = 0;
                        o3 = 20000;
                    end
                end
            endcase
            m_gate = ng;
            o2 = ng ? 20000 : 0;
            exp_q.push_back({16'(o0), 16'(o1), 16'(o2), 16'(o3)});
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge sample_clk);
        #1;
        if (exp_q.size() == 0)
            check_val("queue_empty", 64'd1, 64'd0);
        else
            check_val("outs", {out0, out1, out2, out3}, exp_q.pop_front());
    endtask

    initial begin
        int n, eoc, prev, lo, k, e, d;
        bit mono;
        logic signed [15:0] pre;

        // reset with a live gate
        in0 = 16'sd10000; in1 = 16'sd8000; in2 = '0; in3 = '0; rst = 1'b1;
        repeat (3) tick();
        check_val("rst_outs", {out0, out1, out2, out3}, 64'd0);
        rst = 1'b0; in1 = '0;
        repeat (2) tick();
        check_val("post_rst_outs", {out0, out1, out2, out3}, 64'd0);

        // fastest attack
        in1 = 16'sd8000;
        tick();
        n = 0;
        while (out1 != 16'sd32767 && n < 3000) begin tick(); n++; end
        check_val("attack_len", 64'(n), 64'd2049);
        check_val("attack_out0", 64'(out0), 64'(9999));
        in0 = -16'sd10000;
        tick();
        check_val("neg_audio", 64'(out0), 64'(-10000));
        repeat (20) begin in0 = 16'($urandom); tick(); end
        in0 = 16'sd10000;

        // Schmitt hysteresis
        in1 = 16'sd3000;
        repeat (3) tick();
        check_val("schmitt_hold", 64'(out2), 64'd20000);
        in1 = 16'sd1999;
        tick();
        check_val("schmitt_clear", 64'(out2), 64'd0);

        // release to idle
        n = 0; eoc = 0; mono = 1'b1; prev = out1;
        while (eoc == 0 && n < 5000) begin
            tick(); n++;
            if (out3 == 16'sd20000) eoc++;
            if (out1 > prev) mono = 1'b0;
            prev = out1;
        end
`ifdef ENV_VCA_EXP_RELEASE_EN
        e = 24'hFFFFFF; k = 0;
        while (e != 0) begin
            d = e >> 4;
            if (d < 1) d = 1;
            e = (e > d) ? e - d : 0;
            k++;
        end
`else
        k = 2048;
`endif
        check_val("release_len", 64'(n), 64'(k));
        check_val("release_mono", 64'(mono), 64'd1);
        repeat (5) begin tick(); if (out3 != 0) eoc++; end
        check_val("eoc_single", 64'(eoc), 64'd1);
        check_val("idle_lvl", 64'(out1), 64'd0);

        // retrigger mid-release
        in1 = 16'sd8000;
        n = 0;
        while (out1 != 16'sd32767 && n < 3000) begin tick(); n++; end
        in1 = '0;
        n = 0;
        while (out1 > 16'sh4000 && n < 5000) begin tick(); n++; end
        pre = out1; lo = out1; eoc = 0;
        in1 = 16'sd8000;
        repeat (100) begin
            tick();
            if (out1 < lo) lo = out1;
            if (out3 != 0) eoc++;
        end
        check_val("retrig_no_eoc", 64'(eoc), 64'd0);
        check_val("retrig_no_drop", 64'(lo >= int'(pre) - 16'h0800 && lo > 0), 64'd1);
        check_val("retrig_rises", 64'(out1 > pre), 64'd1);

        // gate low on the saturating attack step
        n = 0;
        while (m_st == 1 && m_env + model_ainc() < 24'hFFFFFF && n < 3000) begin tick(); n++; end
        in1 = '0;
        tick();
        tick();
        check_val("sat_gate_low_lvl", 64'(out1), 64'd32767);

        // gate high on the edge the release would reach zero
        n = 0;
        while (m_st == 3 && m_env > model_dec() && n < 5000) begin tick(); n++; end
        in1 = 16'sd8000;
        eoc = 0;
        repeat (5) begin tick(); if (out3 != 0) eoc++; end
        check_val("zero_retrig_no_eoc", 64'(eoc), 64'd0);
        check_val("zero_retrig_gate", 64'(out2), 64'd20000);

        // reset mid-attack aborts with no EOC
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_val("midrst_outs", {out0, out1, out2, out3}, 64'd0);
        rst = 1'b0; in1 = '0; eoc = 0;
        repeat (5) begin tick(); if (out3 != 0) eoc++; end
        check_val("midrst_no_eoc", 64'(eoc), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
